// File: rtl/fft_pkg.sv
// Shared sizes, state/stage types, butterfly descriptor layout and the W16^k table
// for the 16-point radix-2 DIT FFT butterfly scheduler.
package fft_pkg;

    localparam int unsigned LOG2N      = 4;
    localparam int unsigned N          = 1 << LOG2N;
    localparam int unsigned NUM_BF     = N / 2;
    localparam int unsigned NUM_STAGES = LOG2N;
    localparam int unsigned TW_W       = 16;

    typedef logic [1:0] stage_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [LOG2N-1:0] addr_a;
        logic [LOG2N-1:0] addr_b;
        logic [LOG2N-2:0] tw_idx;
    } bf_desc_t;

    // Q2.14 cos/-sin of 2*pi*k/16, k = 0..7
    localparam logic signed [TW_W-1:0] TW_RE [0:7] = '{
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
        16'sd0, -16'sd6270, -16'sd11585, -16'sd15137};
    localparam logic signed [TW_W-1:0] TW_IM [0:7] = '{
        16'sd0, -16'sd6270, -16'sd11585, -16'sd15137,
        -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270};

    // Butterfly b of stage s: legs are half apart inside groups of 2*half samples.
    function automatic bf_desc_t bf_desc(input stage_t s, input logic [2:0] b);
        bf_desc_t   d;
        logic [2:0] pos;
        logic [3:0] half;
        logic [3:0] base;
        half     = 4'd1 << s;
        pos      = b & 3'(half - 4'd1);
        base     = (4'(b >> s) << s) << 1;
        d.addr_a = base + 4'(pos);
        d.addr_b = d.addr_a + half;
        d.tw_idx = pos << (2'd3 - s);
        return d;
    endfunction

endpackage

// File: rtl/fft16_bf_scheduler_if.sv
// Control/descriptor bundle between the butterfly scheduler (master) and the
// datapath/host side (slave).
interface fft16_bf_scheduler_if;
    import fft_pkg::*;

    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [LOG2N-1:0]       addr_a;
    logic [LOG2N-1:0]       addr_b;
    logic [LOG2N-2:0]       tw_idx;
    logic signed [TW_W-1:0] tw_re;
    logic signed [TW_W-1:0] tw_im;
    logic [1:0]             stage;
    logic                   wb_valid;
    logic                   err;

    modport master (
        input  start, issue_ready, wb_valid,
        output busy, done, issue_valid, addr_a, addr_b, tw_idx,
               tw_re, tw_im, stage, err
    );

    modport slave (
        output start, issue_ready, wb_valid,
        input  busy, done, issue_valid, addr_a, addr_b, tw_idx,
               tw_re, tw_im, stage, err
    );

endinterface

// File: rtl/fft16_twiddle_rom.sv
// Combinational W16^k lookup: exponent in, Q2.14 real/imaginary parts out.
module fft16_twiddle_rom
    import fft_pkg::*;
(
    input  logic [LOG2N-2:0]       i_tw_idx,
    output logic signed [TW_W-1:0] o_tw_re_c,
    output logic signed [TW_W-1:0] o_tw_im_c
);

    always_comb begin
        o_tw_re_c = TW_RE[i_tw_idx];
        o_tw_im_c = TW_IM[i_tw_idx];
    end

endmodule

// File: rtl/fft16_bf_scheduler.sv
// Walks 4 stages x 8 butterflies of an in-place 16-point DIT FFT, issuing one
// descriptor per handshake and holding each stage until its 8 writebacks land.
module fft16_bf_scheduler
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    fft16_bf_scheduler_if.master    bus
);

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_issue_valid;
    bf_desc_t       r_desc;
    stage_t         r_stage;
    logic [2:0]     r_bf_cnt;
    logic [3:0]     r_wb_cnt;
    logic           r_err;

    logic                   w_hs;
    logic                   w_counting;
    logic [3:0]             w_wb_sum;
    logic signed [TW_W-1:0] w_tw_re;
    logic signed [TW_W-1:0] w_tw_im;

    assign w_hs       = r_issue_valid & bus.issue_ready;
    assign w_counting = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_wb_sum   = r_wb_cnt + 4'(bus.wb_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_issue_valid <= 1'b0;
            r_desc        <= '0;
            r_stage       <= '0;
            r_bf_cnt      <= '0;
            r_wb_cnt      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Writebacks beyond 8 per stage, or after the last stage, are flagged, not counted
            if (w_counting && bus.wb_valid) begin
                if (r_wb_cnt == 4'(NUM_BF)) r_err <= 1'b1;
                else                        r_wb_cnt <= r_wb_cnt + 4'd1;
            end
            if ((r_state == ST_DONE) && bus.wb_valid) r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state       <= ST_ISSUE;
                        r_busy        <= 1'b1;
                        r_issue_valid <= 1'b1;
                        r_stage       <= '0;
                        r_bf_cnt      <= '0;
                        r_wb_cnt      <= '0;
                        r_err         <= 1'b0;
                        r_desc        <= bf_desc(2'd0, 3'd0);
                    end
                end
                ST_ISSUE: begin
                    if (w_hs) begin
                        if (r_bf_cnt == 3'(NUM_BF - 1)) begin
                            r_state       <= ST_DRAIN;
                            r_issue_valid <= 1'b0;
                        end else begin
                            r_bf_cnt <= r_bf_cnt + 3'd1;
                            r_desc   <= bf_desc(r_stage, r_bf_cnt + 3'd1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The writeback arriving this cycle already counts toward the 8
                    if (w_wb_sum >= 4'(NUM_BF)) begin
                        if (r_stage != 2'(NUM_STAGES - 1)) begin
                            r_state       <= ST_ISSUE;
                            r_issue_valid <= 1'b1;
                            r_stage       <= r_stage + 2'd1;
                            r_bf_cnt      <= '0;
                            r_wb_cnt      <= '0;
                            r_desc        <= bf_desc(r_stage + 2'd1, 3'd0);
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    fft16_twiddle_rom u_rom (
        .i_tw_idx  (r_desc.tw_idx),
        .o_tw_re_c (w_tw_re),
        .o_tw_im_c (w_tw_im)
    );

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.issue_valid = r_issue_valid;
    assign bus.addr_a      = r_desc.addr_a;
    assign bus.addr_b      = r_desc.addr_b;
    assign bus.tw_idx      = r_desc.tw_idx;
    assign bus.tw_re       = w_tw_re;
    assign bus.tw_im       = w_tw_im;
    assign bus.stage       = r_stage;
    assign bus.err         = r_err;

endmodule
